// File: rtl/fifo_pkg.sv
// Shared definitions for the packet-merge FIFOs: default geometry and the
// status-flag function used to register FULL_N / ALMOST_* from the next count.
package fifo_pkg;

   localparam int PKT_DW = 153;
   localparam int DEF_AW = 4;

   typedef struct packed {
      logic full_n;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic fifo_flags_t calc_flags(
      input int next_count,
      input int af_lvl,
      input int ae_lvl,
      input int depth
   );
      fifo_flags_t f;
      f.full_n       = (next_count < depth);
      f.almost_full  = (next_count >= af_lvl);
      f.almost_empty = (next_count <= ae_lvl);
      return f;
   endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register has a synchronous clear so the FIFO output can return to zero.
module fifo_ram_sdp #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic          rd_clr,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [0:(1 << AW)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-before-write on a shared address: the old word is returned.
   always_ff @(posedge clk) begin
      if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/pkt_fifo_sc_param.sv
// Parametrised single-clock packet FIFO with optional first-word-fall-through,
// exact occupancy, registered almost-full/empty flags and sticky OVF/UDF.
module pkt_fifo_sc_param
   import fifo_pkg::*;
#(
   parameter int DW     = PKT_DW,
   parameter int AW     = DEF_AW,
   parameter int AF_LVL = (1 << AW) - 2,
   parameter int AE_LVL = 1,
   parameter bit FWFT   = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] d_in,
   input  logic          enq,
   input  logic          deq,
   output logic [DW-1:0] d_out,
   output logic          full_n,
   output logic          empty_n,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          ovf,
   output logic          udf
);

   localparam int DEPTH = 1 << AW;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pf_valid;

   logic          clear;
   logic          deq_acc;
   logic          enq_acc;
   logic          ram_rd;
   logic          pf_valid_nxt;
   logic          empty_n_nxt;
   logic [AW:0]   count_nxt;
   logic [AW:0]   pf_ext;
   fifo_flags_t   flags_nxt;

   assign clear = rst || clr;

   always_comb begin
      pf_ext       = {{AW{1'b0}}, pf_valid};
      deq_acc      = deq && empty_n;
      enq_acc      = enq && (full_n || deq_acc);
      count_nxt    = count;
      ram_rd       = 1'b0;
      pf_valid_nxt = 1'b0;
      empty_n_nxt  = 1'b0;

      if (enq_acc && !deq_acc) begin
         count_nxt = count + {{AW{1'b0}}, 1'b1};
      end else if (deq_acc && !enq_acc) begin
         count_nxt = count - {{AW{1'b0}}, 1'b1};
      end

      if (FWFT) begin
         // Words still in RAM = count minus the one held in the read register.
         // A word written on this edge is not counted yet, so it is never
         // read back in the same cycle it is written.
         ram_rd       = (count > pf_ext) && (!pf_valid || deq_acc);
         pf_valid_nxt = ram_rd || (pf_valid && !deq_acc);
         empty_n_nxt  = pf_valid_nxt;
      end else begin
         ram_rd      = deq_acc;
         empty_n_nxt = (count_nxt != '0);
      end

      flags_nxt = calc_flags(int'(count_nxt), AF_LVL, AE_LVL, DEPTH);
   end

   // In FWFT mode the RAM read register doubles as the prefetch register.
   fifo_ram_sdp #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (enq_acc && !clear),
      .wr_addr (wr_ptr),
      .wr_data (d_in),
      .rd_en   (ram_rd && !clear),
      .rd_clr  (clear),
      .rd_addr (rd_ptr),
      .rd_data (d_out)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         pf_valid     <= 1'b0;
         full_n       <= 1'b1;
         empty_n      <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         ovf          <= 1'b0;
         udf          <= 1'b0;
      end else begin
         if (enq_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count        <= count_nxt;
         pf_valid     <= pf_valid_nxt;
         full_n       <= flags_nxt.full_n;
         empty_n      <= empty_n_nxt;
         almost_full  <= flags_nxt.almost_full;
         almost_empty <= flags_nxt.almost_empty;
         if (enq && !enq_acc) begin
            ovf <= 1'b1;
         end
         if (deq && !deq_acc) begin
            udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pkt_fifo_sc_param.sv
// Self-checking bench: one FWFT instance (AW=4) and one registered-read instance (AW=2).
module tb_pkt_fifo_sc_param;

   localparam int DW = 153;

   localparam logic [163:0] F_RST = {153'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
   localparam logic [161:0] N_RST = {153'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          f_rst, f_clr, f_enq, f_deq;
   logic [DW-1:0] f_d_in, f_d_out;
   logic          f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_ovf, f_udf;
   logic [4:0]    f_count;

   logic          n_rst, n_clr, n_enq, n_deq;
   logic [DW-1:0] n_d_in, n_d_out;
   logic          n_full_n, n_empty_n, n_almost_full, n_almost_empty, n_ovf, n_udf;
   logic [2:0]    n_count;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [DW-1:0] sb_q [$];

   pkt_fifo_sc_param #(
      .DW(DW), .AW(4), .AF_LVL(14), .AE_LVL(1), .FWFT(1'b1)
   ) u_fwft (
      .clk(clk), .rst(f_rst), .clr(f_clr), .d_in(f_d_in), .enq(f_enq), .deq(f_deq),
      .d_out(f_d_out), .full_n(f_full_n), .empty_n(f_empty_n),
      .almost_full(f_almost_full), .almost_empty(f_almost_empty),
      .count(f_count), .ovf(f_ovf), .udf(f_udf)
   );

   pkt_fifo_sc_param #(
      .DW(DW), .AW(2), .AF_LVL(2), .AE_LVL(1), .FWFT(1'b0)
   ) u_nofwft (
      .clk(clk), .rst(n_rst), .clr(n_clr), .d_in(n_d_in), .enq(n_enq), .deq(n_deq),
      .d_out(n_d_out), .full_n(n_full_n), .empty_n(n_empty_n),
      .almost_full(n_almost_full), .almost_empty(n_almost_empty),
      .count(n_count), .ovf(n_ovf), .udf(n_udf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic test_reset();
      f_rst = 1'b1; n_rst = 1'b1;
      tick();
      tick();
      f_rst = 1'b0; n_rst = 1'b0;
      vec_cnt++;
      if ({f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf} !== F_RST) begin
         err_cnt++;
         $display("FAIL reset_fwft: got %h need %h",
                  {f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf}, F_RST);
      end
      vec_cnt++;
      if ({n_d_out, n_full_n, n_empty_n, n_almost_full, n_almost_empty, n_count, n_ovf, n_udf} !== N_RST) begin
         err_cnt++;
         $display("FAIL reset_nofwft: got %h need %h",
                  {n_d_out, n_full_n, n_empty_n, n_almost_full, n_almost_empty, n_count, n_ovf, n_udf}, N_RST);
      end
   endtask

   task automatic test_fill();
      sb_q.delete();
      for (int i = 0; i < 16; i++) begin
         f_enq  = 1'b1;
         f_d_in = DW'(i);
         sb_q.push_back(DW'(i));
         tick();
         vec_cnt++;
         if (f_count !== 5'(i + 1) || f_full_n !== (i < 15) || f_almost_full !== (i >= 13) ||
             f_almost_empty !== (i == 0) || f_empty_n !== (i >= 1)) begin
            err_cnt++;
            $display("FAIL fill_status[%0d]: got count=%0d full_n=%b af=%b ae=%b empty_n=%b need count=%0d full_n=%b af=%b ae=%b empty_n=%b",
                     i, f_count, f_full_n, f_almost_full, f_almost_empty, f_empty_n,
                     i + 1, (i < 15), (i >= 13), (i == 0), (i >= 1));
         end
         if (i >= 1) begin
            vec_cnt++;
            if (f_d_out !== '0) begin
               err_cnt++;
               $display("FAIL fill_head[%0d]: got %h need 0", i, f_d_out);
            end
         end
      end
      f_enq = 1'b0;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] exp;
      f_enq  = 1'b1;
      f_d_in = DW'(99);
      tick();
      f_enq = 1'b0;
      vec_cnt++;
      if (f_ovf !== 1'b1 || f_count !== 5'd16 || f_full_n !== 1'b0 || f_udf !== 1'b0) begin
         err_cnt++;
         $display("FAIL overflow: got ovf=%b count=%0d full_n=%b udf=%b need ovf=1 count=16 full_n=0 udf=0",
                  f_ovf, f_count, f_full_n, f_udf);
      end
      for (int i = 0; i < 16; i++) begin
         exp = sb_q.pop_front();
         vec_cnt++;
         if (f_empty_n !== 1'b1 || f_d_out !== exp) begin
            err_cnt++;
            $display("FAIL drain[%0d]: got empty_n=%b data=%h need empty_n=1 data=%h", i, f_empty_n, f_d_out, exp);
         end
         f_deq = 1'b1;
         tick();
      end
      f_deq = 1'b0;
      vec_cnt++;
      if (f_count !== 5'd0 || f_empty_n !== 1'b0 || f_udf !== 1'b0) begin
         err_cnt++;
         $display("FAIL drain_end: got count=%0d empty_n=%b udf=%b need 0 0 0", f_count, f_empty_n, f_udf);
      end
   endtask

   task automatic test_underflow_clear();
      f_deq = 1'b1;
      tick();
      f_deq = 1'b0;
      vec_cnt++;
      if (f_udf !== 1'b1 || f_count !== 5'd0 || f_ovf !== 1'b1) begin
         err_cnt++;
         $display("FAIL underflow: got udf=%b count=%0d ovf=%b need udf=1 count=0 ovf=1", f_udf, f_count, f_ovf);
      end
      f_clr = 1'b1;
      tick();
      f_clr = 1'b0;
      vec_cnt++;
      if ({f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf} !== F_RST) begin
         err_cnt++;
         $display("FAIL clear: got %h need %h",
                  {f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf}, F_RST);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w;
      logic [DW-1:0] exp;
      logic          do_enq;
      logic          do_deq;
      int            mcount;
      sb_q.delete();
      for (int i = 0; i < 16; i++) begin
         w = rnd_word();
         sb_q.push_back(w);
         f_enq = 1'b1; f_d_in = w;
         tick();
      end
      f_enq = 1'b0;
      // simultaneous on full
      exp = sb_q.pop_front();
      vec_cnt++;
      if (f_d_out !== exp) begin
         err_cnt++;
         $display("FAIL simul_full_head: got %h need %h", f_d_out, exp);
      end
      w = rnd_word();
      sb_q.push_back(w);
      f_enq = 1'b1; f_deq = 1'b1; f_d_in = w;
      tick();
      f_enq = 1'b0; f_deq = 1'b0;
      vec_cnt++;
      if (f_count !== 5'd16 || f_full_n !== 1'b0 || f_ovf !== 1'b0) begin
         err_cnt++;
         $display("FAIL simul_full: got count=%0d full_n=%b ovf=%b need count=16 full_n=0 ovf=0", f_count, f_full_n, f_ovf);
      end
      for (int i = 0; i < 15; i++) begin
         exp = sb_q.pop_front();
         vec_cnt++;
         if (f_d_out !== exp || f_empty_n !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_drain[%0d]: got empty_n=%b data=%h need empty_n=1 data=%h", i, f_empty_n, f_d_out, exp);
         end
         f_deq = 1'b1;
         tick();
      end
      f_deq = 1'b0;
      // simultaneous at one word
      exp = sb_q.pop_front();
      vec_cnt++;
      if (f_count !== 5'd1 || f_empty_n !== 1'b1 || f_d_out !== exp) begin
         err_cnt++;
         $display("FAIL simul_one_head: got count=%0d empty_n=%b data=%h need count=1 empty_n=1 data=%h",
                  f_count, f_empty_n, f_d_out, exp);
      end
      w = rnd_word();
      sb_q.push_back(w);
      f_enq = 1'b1; f_deq = 1'b1; f_d_in = w;
      tick();
      f_enq = 1'b0; f_deq = 1'b0;
      vec_cnt++;
      if (f_count !== 5'd1) begin
         err_cnt++;
         $display("FAIL simul_one: got count=%0d need 1", f_count);
      end
      mcount = 1;
      for (int k = 0; k < 40; k++) begin
         do_deq = f_empty_n && ($urandom_range(0, 1) == 1);
         do_enq = ($urandom_range(0, 2) != 0) && (mcount < 16 || do_deq);
         if (do_deq) begin
            vec_cnt++;
            if (sb_q.size() == 0) begin
               err_cnt++;
               $display("FAIL mixed_pop[%0d]: got empty_n=1 data=%h need no data", k, f_d_out);
            end else begin
               exp = sb_q.pop_front();
               if (f_d_out !== exp) begin
                  err_cnt++;
                  $display("FAIL mixed_pop[%0d]: got %h need %h", k, f_d_out, exp);
               end
            end
         end
         w = rnd_word();
         if (do_enq) sb_q.push_back(w);
         f_enq = do_enq; f_deq = do_deq; f_d_in = w;
         tick();
         f_enq = 1'b0; f_deq = 1'b0;
         mcount = mcount + int'(do_enq) - int'(do_deq);
         vec_cnt++;
         if (f_count !== 5'(mcount)) begin
            err_cnt++;
            $display("FAIL mixed_count[%0d]: got %0d need %0d", k, f_count, mcount);
         end
      end
      for (int c = 0; c < 80 && mcount > 0; c++) begin
         do_deq = f_empty_n;
         if (do_deq) begin
            vec_cnt++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
            if (f_d_out !== exp) begin
               err_cnt++;
               $display("FAIL final_drain[%0d]: got %h need %h", c, f_d_out, exp);
            end
         end
         f_deq = do_deq;
         tick();
         f_deq = 1'b0;
         mcount = mcount - int'(do_deq);
      end
      vec_cnt++;
      if (mcount != 0 || sb_q.size() != 0 || f_count !== 5'd0 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
         err_cnt++;
         $display("FAIL mixed_end: got left=%0d queued=%0d count=%0d ovf=%b udf=%b need all 0",
                  mcount, sb_q.size(), f_count, f_ovf, f_udf);
      end
   endtask

   task automatic test_rst_mid();
      logic [DW-1:0] w;
      bit            seen;
      for (int i = 0; i < 9; i++) begin
         f_enq = 1'b1; f_d_in = rnd_word();
         tick();
      end
      vec_cnt++;
      if (f_count !== 5'd9) begin
         err_cnt++;
         $display("FAIL rst_pre_count: got %0d need 9", f_count);
      end
      f_enq = 1'b1; f_deq = 1'b1; f_rst = 1'b1; f_d_in = rnd_word();
      tick();
      f_enq = 1'b0; f_deq = 1'b0; f_rst = 1'b0;
      sb_q.delete();
      vec_cnt++;
      if ({f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf} !== F_RST) begin
         err_cnt++;
         $display("FAIL rst_mid: got %h need %h",
                  {f_d_out, f_full_n, f_empty_n, f_almost_full, f_almost_empty, f_count, f_ovf, f_udf}, F_RST);
      end
      w = rnd_word();
      sb_q.push_back(w);
      f_enq = 1'b1; f_d_in = w;
      tick();
      f_enq = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         tick();
         seen = f_empty_n;
      end
      vec_cnt++;
      if (!seen || f_d_out !== sb_q[0] || f_count !== 5'd1) begin
         err_cnt++;
         $display("FAIL rst_next_word: got empty_n=%b data=%h count=%0d need empty_n=1 data=%h count=1",
                  f_empty_n, f_d_out, f_count, sb_q[0]);
      end
   endtask

   task automatic test_no_fwft();
      logic [DW-1:0] a;
      logic [DW-1:0] exp;
      sb_q.delete();
      a = rnd_word();
      sb_q.push_back(a);
      n_enq = 1'b1; n_d_in = a;
      tick();
      vec_cnt++;
      if (n_empty_n !== 1'b1 || n_count !== 3'd1 || n_d_out !== '0) begin
         err_cnt++;
         $display("FAIL nf_first: got empty_n=%b count=%0d data=%h need 1 1 0", n_empty_n, n_count, n_d_out);
      end
      n_d_in = rnd_word();
      sb_q.push_back(n_d_in);
      tick();
      n_enq = 1'b0;
      vec_cnt++;
      if (n_count !== 3'd2 || n_almost_full !== 1'b1 || n_full_n !== 1'b1 || n_almost_empty !== 1'b0) begin
         err_cnt++;
         $display("FAIL nf_two: got count=%0d af=%b full_n=%b ae=%b need 2 1 1 0",
                  n_count, n_almost_full, n_full_n, n_almost_empty);
      end
      n_deq = 1'b1;
      tick();
      n_deq = 1'b0;
      exp = sb_q.pop_front();
      vec_cnt++;
      if (n_d_out !== exp || n_count !== 3'd1 || n_empty_n !== 1'b1) begin
         err_cnt++;
         $display("FAIL nf_deq_a: got data=%h count=%0d empty_n=%b need data=%h count=1 empty_n=1",
                  n_d_out, n_count, n_empty_n, exp);
      end
      tick();
      vec_cnt++;
      if (n_d_out !== exp) begin
         err_cnt++;
         $display("FAIL nf_hold: got %h need %h", n_d_out, exp);
      end
      n_deq = 1'b1;
      tick();
      n_deq = 1'b0;
      exp = sb_q.pop_front();
      vec_cnt++;
      if (n_d_out !== exp || n_count !== 3'd0 || n_empty_n !== 1'b0) begin
         err_cnt++;
         $display("FAIL nf_deq_b: got data=%h count=%0d empty_n=%b need data=%h count=0 empty_n=0",
                  n_d_out, n_count, n_empty_n, exp);
      end
      for (int i = 0; i < 5; i++) begin
         n_enq = 1'b1; n_d_in = rnd_word();
         if (i < 4) sb_q.push_back(n_d_in);
         tick();
      end
      n_enq = 1'b0;
      vec_cnt++;
      if (n_count !== 3'd4 || n_full_n !== 1'b0 || n_ovf !== 1'b1) begin
         err_cnt++;
         $display("FAIL nf_full: got count=%0d full_n=%b ovf=%b need 4 0 1", n_count, n_full_n, n_ovf);
      end
      for (int i = 0; i < 4; i++) begin
         n_deq = 1'b1;
         tick();
         exp = sb_q.pop_front();
         vec_cnt++;
         if (n_d_out !== exp) begin
            err_cnt++;
            $display("FAIL nf_order[%0d]: got %h need %h", i, n_d_out, exp);
         end
      end
      tick();
      n_deq = 1'b0;
      vec_cnt++;
      if (n_udf !== 1'b1 || n_count !== 3'd0 || n_empty_n !== 1'b0) begin
         err_cnt++;
         $display("FAIL nf_udf: got udf=%b count=%0d empty_n=%b need 1 0 0", n_udf, n_count, n_empty_n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 need finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      f_rst = 1'b0; f_clr = 1'b0; f_enq = 1'b0; f_deq = 1'b0; f_d_in = '0;
      n_rst = 1'b0; n_clr = 1'b0; n_enq = 1'b0; n_deq = 1'b0; n_d_in = '0;
      test_reset();
      test_fill();
      test_overflow();
      test_underflow_clear();
      test_back_to_back();
      test_rst_mid();
      test_no_fwft();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/pkt_fifo_sc_param.md
# pkt_fifo_sc_param

Parametrised single-clock FIFO for the packet-merge datapath. It replaces the fixed 153-bit × 16 packet FIFO with configurable width and depth and adds:
- a first-word-fall-through (FWFT) output mode,
- programmable almost-full/almost-empty thresholds and an exact occupancy count,
- guarded enqueue/dequeue with sticky overflow/underflow error flags.

It sits between each merge input port and the arbiter, and on the merged output port.

## Interface
- DW, 153, data width in bits.
- AW, 4, address width; DEPTH = 2^AW words.
- AF_LVL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LVL; legal range 1..DEPTH.
- AE_LVL, 1, ALMOST_EMPTY asserts when COUNT <= AE_LVL; legal range 0..DEPTH-1.
- FWFT, 1, 1 = head word presented on D_OUT without DEQ; 0 = registered read on DEQ.

- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous clear; same effect as RST.
- D_IN  in  DW  enqueue data.
- ENQ  in  1  enqueue request.
- DEQ  in  1  dequeue request.
- D_OUT  out  DW  head or read data.
- FULL_N  out  1  space available (COUNT < DEPTH).
- EMPTY_N  out  1  data available; in FWFT mode, head valid on D_OUT.
- ALMOST_FULL  out  1  COUNT >= AF_LVL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LVL.
- COUNT  out  AW+1  words enqueued and not yet dequeued, 0..DEPTH.
- OVF  out  1  sticky: ENQ was refused.
- UDF  out  1  sticky: DEQ was refused.

## Operation
- Accepted enqueue: ENQ && (FULL_N || DEQ_acc). Otherwise ENQ is dropped, the write pointer is unchanged, and OVF is set.
- Accepted dequeue: DEQ && EMPTY_N. Otherwise DEQ is dropped and UDF is set.
- Simultaneous accepted ENQ and DEQ: COUNT unchanged; both pointers advance.
- ENQ on full is accepted when DEQ is accepted in the same cycle.
- Pointers are AW bits and wrap modulo DEPTH. Full/empty are decided from COUNT, never from pointer equality.
- COUNT update per edge: +1 for enqueue only, -1 for dequeue only, else hold. COUNT never exceeds DEPTH and never underflows.
- All status outputs are registered and computed from the next-state COUNT, so they change on the same edge as COUNT.
- FWFT=1:
  - A prefetch register holds the head word. The RAM read pointer advances when the prefetch register is loaded.
  - The prefetch register loads when it is empty, or when it is dequeued and the RAM holds further words.
  - EMPTY_N equals prefetch-valid.
- FWFT=0:
  - The RAM read issues on an accepted DEQ; D_OUT is the RAM read register.
  - EMPTY_N equals (next COUNT != 0).
- RST or CLR, with RST taking priority over CLR, and both over ENQ/DEQ in the same cycle:
  - pointers, COUNT, prefetch-valid and OVF/UDF are cleared;
  - RAM contents are not cleared.
- Reset values: D_OUT=0, FULL_N=1, EMPTY_N=0, ALMOST_FULL=0, ALMOST_EMPTY=1, COUNT=0, OVF=0, UDF=0.
- RST asserted mid-packet discards all contents. No partial word survives.

## Timing
- FWFT=1:
  - ENQ into an empty FIFO at edge t makes COUNT=1 after t.
  - The word appears on D_OUT with EMPTY_N=1 after edge t+1.
  - COUNT=1 with EMPTY_N=0 for exactly one cycle is legal.
- FWFT=1, back-to-back DEQ: sustains one word per cycle with no bubble while COUNT >= 2.
- FWFT=0: DEQ accepted at edge t puts data on D_OUT after edge t; D_OUT holds until the next accepted DEQ.
- ENQ-to-FULL_N latency is 1 edge; DEQ-to-FULL_N latency is 1 edge.
- Throughput is one ENQ and one DEQ per cycle.
- Critical path limit: COUNT compare plus flag register. No combinational path from inputs to outputs.

## Structure
- Shared package fifo_pkg holds:
  - PKT_DW=153 and default AW=4;
  - a function for the status-flag computation, f(next_count, AF_LVL, AE_LVL, DEPTH).
- Sub-module fifo_ram_sdp: parametrised (DW, AW) simple dual-port RAM with one write port and one registered read port with read enable. It maps to block RAM.
- The top level contains the pointers, COUNT, flags, error logic and the FWFT prefetch stage.

## Test plan
- Reset then fill (FWFT=1, DW=153, AW=4): 16 ENQs with data i = 0..15.
  - COUNT reaches 16, FULL_N=0.
  - ALMOST_FULL rises when COUNT reaches 14.
  - D_OUT=0 with EMPTY_N=1, from 2 cycles after the first ENQ.
- Overflow: 17th ENQ on full, DEQ low.
  - OVF=1, COUNT stays 16.
  - A subsequent drain returns exactly 0..15 in order.
- Underflow and clear: DEQ on empty sets UDF=1 with COUNT=0. Then CLR=1 for one cycle clears OVF/UDF; all outputs return to reset values.
- Simultaneous ENQ+DEQ on full, then on COUNT=1:
  - COUNT is unchanged in both cases;
  - ordering is preserved across the pointer wrap, after 40 mixed operations checked against a scoreboard.
- FWFT=0 with AW=2: ENQ A,B then DEQ at edge t. D_OUT=A after t; D_OUT=B after the next accepted DEQ; EMPTY_N=0 after the second DEQ.
- RST asserted with COUNT=9 while ENQ and DEQ are both high: all outputs take reset values after that edge, and the next ENQ'd word is the next word read out.
